// File: rtl/sif_norm_pkg.sv
// Shared constants and FSM state type for the sum-of-squares / rsqrt normalisation path.
package sif_norm_pkg;

  localparam int          FP16_BIAS    = 15;
  localparam int          FP16_EXP_SAT = 31;
  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_MAX     = 16'h7BFF;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sif_u2half_cvt.sv
// Combinational unsigned-integer (>=1) to IEEE-754 binary16 converter with
// round-to-nearest-even and saturation to max finite.
module sif_u2half_cvt
  import sif_norm_pkg::*;
#(
  parameter int V_W = 32
) (
  input  logic [V_W-1:0] v,
  output logic [15:0]    fp,
  output logic           sat
);

  localparam int IDX_W = $clog2(V_W);
  localparam int E_W   = IDX_W + 2;

  logic [IDX_W-1:0] msb;
  logic [IDX_W-1:0] sh;
  logic [V_W-1:0]   norm;
  logic [9:0]       mant_raw;
  logic             guard;
  logic             sticky;
  logic             rnd;
  logic [10:0]      mant_sum;
  logic [E_W-1:0]   exp_full;

  always_comb begin
    msb = '0;
    for (int i = 0; i < V_W; i++) begin
      if (v[i]) msb = i[IDX_W-1:0];
    end

    // Left-justify so the leading one sits in the top bit; the mantissa,
    // guard and sticky positions are then fixed regardless of magnitude.
    sh       = IDX_W'(V_W - 1) - msb;
    norm     = v << sh;
    mant_raw = norm[V_W-2 -: 10];
    guard    = norm[V_W-12];
    sticky   = |norm[V_W-13:0];
    rnd      = guard & (sticky | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {10'd0, rnd};
    exp_full = E_W'(msb) + E_W'(FP16_BIAS) + E_W'(mant_sum[10]);

    sat = norm[V_W-1] && (exp_full >= E_W'(FP16_EXP_SAT));
    if (!norm[V_W-1]) begin
      fp = 16'h0000;
    end else if (sat) begin
      fp = FP16_MAX;
    end else begin
      fp = {1'b0, exp_full[4:0], mant_sum[9:0]};
    end
  end

endmodule

// File: rtl/sif_sumsq_mean_half_fp.sv
// Per-vector mean of squares plus epsilon, emitted as binary16 for the rsqrt stage.
// Optional sticky saturation output enabled by macro SIF_SUMSQ_SAT_FLAG_EN.
module sif_sumsq_mean_half_fp
  import sif_norm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 6,
  parameter int EPS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     A_vld,
  input  logic signed [DATA_W-1:0] A_dat,
  output logic                     A_rdy,
  output logic                     P_vld,
  output logic [15:0]              P_dat,
  input  logic                     P_rdy
`ifdef SIF_SUMSQ_SAT_FLAG_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int ACC_W = 2*DATA_W + LOG2_N;
  localparam int V_W   = 2*DATA_W;

  state_t              state_reg, state_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [LOG2_N-1:0]   cnt_reg, cnt_next;
  logic [15:0]         p_dat_reg, p_dat_next;
  logic signed [V_W-1:0] sq;
  logic [V_W-1:0]      v;
  logic [15:0]         cvt_fp;
  logic                cvt_sat;

  assign sq = A_dat * A_dat;
  // Dropping LOG2_N low bits of a 2*DATA_W+LOG2_N accumulator leaves exactly V_W bits.
  assign v  = acc_reg[ACC_W-1:LOG2_N] + V_W'(EPS);

  sif_u2half_cvt #(
    .V_W (V_W)
  ) u_cvt (
    .v   (v),
    .fp  (cvt_fp),
    .sat (cvt_sat)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    p_dat_next = p_dat_reg;
    case (state_reg)
      ACC: begin
        if (A_vld) begin
          acc_next = acc_reg + ACC_W'($unsigned(sq));
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == '1) state_next = CONV;
        end
      end
      CONV: begin
        p_dat_next = cvt_sat ? FP16_MAX : cvt_fp;
        state_next = OUT;
      end
      OUT: begin
        if (P_rdy) begin
          state_next = ACC;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_dat_reg <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      p_dat_reg <= p_dat_next;
    end
  end

`ifdef SIF_SUMSQ_SAT_FLAG_EN
  logic sat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else if (state_reg == CONV && cvt_sat) begin
      sat_reg <= 1'b1;
    end
  end

  assign sat_flag = sat_reg;
`endif

  assign A_rdy = (state_reg == ACC);
  assign P_vld = (state_reg == OUT);
  assign P_dat = p_dat_reg;

endmodule

// File: tb/tb_sif_sumsq_mean_half_fp.sv
// Directed bench for sif_sumsq_mean_half_fp: vector table plus stall and reset sequences.
`timescale 1ns/1ps
module tb_sif_sumsq_mean_half_fp;
  import sif_norm_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               A_vld = 1'b0;
  logic signed [15:0] A_dat = '0;
  logic               A_rdy;
  logic               P_vld;
  logic [15:0]        P_dat;
  logic               P_rdy = 1'b1;
`ifdef SIF_SUMSQ_SAT_FLAG_EN
  logic               sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  bit sat_model = 1'b0;

  sif_sumsq_mean_half_fp #(
    .DATA_W (16),
    .LOG2_N (6),
    .EPS    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .A_vld    (A_vld),
    .A_dat    (A_dat),
    .A_rdy    (A_rdy),
    .P_vld    (P_vld),
    .P_dat    (P_dat),
    .P_rdy    (P_rdy)
`ifdef SIF_SUMSQ_SAT_FLAG_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [15:0] va;
    int                 na;
    logic signed [15:0] vb;
    int                 nb;
    logic [15:0]        exp_dat;
    bit                 exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] d);
    int t = 0;
    A_vld = 1'b1;
    A_dat = d;
    while (!A_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!A_rdy) check("a_rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    A_vld = 1'b0;
  endtask

  // Called on the negedge right after the Nth transfer edge, with P_rdy=1.
  task automatic finish_vec(input string name, input logic [15:0] exp_dat);
    check({name, "_conv_pvld"}, {31'd0, P_vld}, 32'd0);
    @(negedge clk);
    check({name, "_out_pvld"}, {31'd0, P_vld}, 32'd1);
    check({name, "_pdat"}, {16'd0, P_dat}, {16'd0, exp_dat});
    $display("result %s: P_dat=%h expected=%h", name, P_dat, exp_dat);
    @(negedge clk);
    check({name, "_post_pvld"}, {31'd0, P_vld}, 32'd0);
    check({name, "_post_ardy"}, {31'd0, A_rdy}, 32'd1);
`ifdef SIF_SUMSQ_SAT_FLAG_EN
    check({name, "_sat_flag"}, {31'd0, sat_flag}, {31'd0, sat_model});
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    for (int k = 0; k < v.na; k++) send(v.va);
    for (int k = 0; k < v.nb; k++) send(v.vb);
    sat_model = sat_model | v.exp_sat;
    finish_vec($sformatf("vec%0d", idx), v.exp_dat);
  endtask

  initial begin
    vecs[0] = '{16'sd3,      64, 16'sd0, 0,  16'h4900,  1'b0};
    vecs[1] = '{16'sd0,      64, 16'sd0, 0,  FP16_ONE,  1'b0};
    vecs[2] = '{16'sd64,     32, 16'sd0, 32, 16'h6800,  1'b0};
    vecs[3] = '{-16'sd32768, 64, 16'sd0, 0,  FP16_MAX,  1'b1};
    vecs[4] = '{16'sd1,      64, 16'sd0, 0,  16'h4000,  1'b0};
    vecs[5] = '{-16'sd3,     64, 16'sd0, 0,  16'h4900,  1'b0};
    vecs[6] = '{16'sd181,    64, 16'sd0, 0,  16'h7800,  1'b0};
    vecs[7] = '{16'sd255,    64, 16'sd0, 0,  16'h7BF0,  1'b0};
    vecs[8] = '{16'sd64,     32, 16'sd2, 32, 16'h6802,  1'b0};

    // Reset state, during and just after reset
    @(negedge clk);
    check("rst_ardy", {31'd0, A_rdy}, 32'd1);
    check("rst_pvld", {31'd0, P_vld}, 32'd0);
    check("rst_pdat", {16'd0, P_dat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ardy", {31'd0, A_rdy}, 32'd1);
    check("post_rst_pvld", {31'd0, P_vld}, 32'd0);
    check("post_rst_pdat", {16'd0, P_dat}, 32'd0);
`ifdef SIF_SUMSQ_SAT_FLAG_EN
    check("post_rst_sat", {31'd0, sat_flag}, 32'd0);
`endif

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Downstream stall in OUT with A_vld held high: 64 x 5 -> V=26 -> 4E80
    P_rdy = 1'b0;
    for (int k = 0; k < 64; k++) send(16'sd5);
    check("stall_conv_pvld", {31'd0, P_vld}, 32'd0);
    @(negedge clk);
    A_vld = 1'b1;
    A_dat = 16'sd100;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall%0d_ardy", c), {31'd0, A_rdy}, 32'd0);
      check($sformatf("stall%0d_pvld", c), {31'd0, P_vld}, 32'd1);
      check($sformatf("stall%0d_pdat", c), {16'd0, P_dat}, 32'h4E80);
      @(negedge clk);
    end
    $display("result stall: P_dat=%h expected=4e80", P_dat);
    P_rdy = 1'b1;
    A_dat = 16'sd3;
    @(negedge clk);
    check("stall_rel_pvld", {31'd0, P_vld}, 32'd0);
    check("stall_rel_ardy", {31'd0, A_rdy}, 32'd1);
    for (int k = 0; k < 64; k++) send(16'sd3);
    finish_vec("after_stall", 16'h4900);

    // Reset while a result is pending in OUT
    P_rdy = 1'b0;
    for (int k = 0; k < 64; k++) send(16'sd3);
    @(negedge clk);
    check("pend_pvld", {31'd0, P_vld}, 32'd1);
    rst = 1'b1;
    #1;
    check("pend_rst_pvld", {31'd0, P_vld}, 32'd0);
    check("pend_rst_pdat", {16'd0, P_dat}, 32'd0);
    sat_model = 1'b0;
`ifdef SIF_SUMSQ_SAT_FLAG_EN
    check("pend_rst_sat", {31'd0, sat_flag}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    P_rdy = 1'b1;
    @(negedge clk);
    check("pend_post_ardy", {31'd0, A_rdy}, 32'd1);
    check("pend_post_pvld", {31'd0, P_vld}, 32'd0);

    // Reset mid-vector: 30 x 7 discarded, then 64 x 3 -> 4900
    for (int k = 0; k < 30; k++) send(16'sd7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ardy", {31'd0, A_rdy}, 32'd1);
    check("mid_rst_pvld", {31'd0, P_vld}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 64; k++) send(16'sd3);
    finish_vec("after_mid_rst", 16'h4900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
